// File: rtl/pulse_sequencer_if.sv
// pulse_sequencer_if -- groups the control/config/status signals of the
// pulse sequencer into one bundle.
//   master : drives start/stop/start_N, period/width/n_pulses, pulse_invert;
//            observes pulse_out, busy, done, pulse_cnt.
//   slave  : the sequencer side (directions reversed).
interface pulse_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic             start_N;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] n_pulses;
   logic             pulse_invert;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulse_cnt;

   modport master (
      output start, stop, start_N, period, width, n_pulses, pulse_invert,
      input  pulse_out, busy, done, pulse_cnt
   );

   modport slave (
      input  start, stop, start_N, period, width, n_pulses, pulse_invert,
      output pulse_out, busy, done, pulse_cnt
   );
endinterface

// File: rtl/pulse_sequencer.sv
// pulse_sequencer -- generates a continuous pulse train (start) or a counted
// burst (start_N) with programmable period and high time.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : pulse_sequencer_if.slave
//          in : start, stop, start_N (one-cycle requests), period, width,
//               n_pulses (latched on acceptance), pulse_invert (live)
//          out: pulse_out (registered), busy, done (one-cycle strobe),
//               pulse_cnt (pulses begun since last accepted start)
module pulse_sequencer #(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   pulse_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN_C, RUN_N} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] npul_q, npul_d;
   logic             pulse_q, pulse_d;
   logic             done_q, done_d;
   logic             last_ph;
   logic             raw_d;

   assign last_ph = (ph_q == period_q - CNT_W'(1));

   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      width_d  = width_q;
      npul_d   = npul_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // start_N is checked first so it wins a same-cycle tie with start.
            if (bus.start_N && (bus.period != '0) && (bus.n_pulses != '0)) begin
               state_d  = RUN_N;
               period_d = bus.period;
               width_d  = bus.width;
               npul_d   = bus.n_pulses;
               ph_d     = '0;
               cnt_d    = CNT_W'(1);   // cleared, then first pulse begins at once
            end else if (bus.start && (bus.period != '0)) begin
               state_d  = RUN_C;
               period_d = bus.period;
               width_d  = bus.width;
               npul_d   = bus.n_pulses;
               ph_d     = '0;
               cnt_d    = CNT_W'(1);
            end
         end
         RUN_C, RUN_N: begin
            if (bus.stop) begin
               // stop takes precedence over burst completion; both end the
               // run the same way so only one done strobe is produced.
               state_d = IDLE;
               ph_d    = '0;
               done_d  = 1'b1;
            end else if ((state_q == RUN_N) && last_ph && (cnt_q == npul_q)) begin
               state_d = IDLE;
               ph_d    = '0;
               done_d  = 1'b1;
            end else if (last_ph) begin
               ph_d = '0;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               ph_d = ph_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            ph_d    = '0;
         end
      endcase

      // Output is computed from next-state values so the registered pulse
      // lines up with the cycle it describes (no extra pipeline delay).
      raw_d   = (state_d != IDLE) && (ph_d < width_d);
      pulse_d = raw_d ^ bus.pulse_invert;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         ph_q     <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         width_q  <= '0;
         npul_q   <= '0;
         pulse_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         width_q  <= width_d;
         npul_q   <= npul_d;
         pulse_q  <= pulse_d;
         done_q   <= done_d;
      end
   end

   assign bus.pulse_out = pulse_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer -- table-driven scenarios plus hand-written reset
// sequences. Expected per-cycle outputs come from closed-form formulas
// (phase = t mod P, count = t div P + 1) and go into a scoreboard queue that
// is checked on the falling edge.
module tb_pulse_sequencer;

   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pulse_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

   pulse_sequencer #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic             po;
      logic             busy;
      logic             done;
      logic [CNT_W-1:0] cnt;
      string            tag;
   } exp_t;

   // kind: 0 start, 1 start_N, 2 both, 3 stop only
   typedef struct {
      int    kind;
      int    period;
      int    width;
      int    n;
      logic  inv;
      int    stop_after;
      string name;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cnt_model = 0;
   vec_t vecs[10];

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (bus_if.pulse_out !== e.po || bus_if.busy !== e.busy ||
             bus_if.done !== e.done || bus_if.pulse_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s: got po=%b busy=%b done=%b cnt=%0d, want po=%b busy=%b done=%b cnt=%0d",
                     e.tag, bus_if.pulse_out, bus_if.busy, bus_if.done, bus_if.pulse_cnt,
                     e.po, e.busy, e.done, e.cnt);
         end else begin
            $display("ok   %s: po=%b busy=%b done=%b cnt=%0d", e.tag,
                     bus_if.pulse_out, bus_if.busy, bus_if.done, bus_if.pulse_cnt);
         end
      end
   end

   // Advance one clock edge (inputs already set) and queue the expected
   // outputs for the cycle that edge produces.
   task automatic tick(input logic po, input logic b, input logic d,
                       input int c, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      e.po   = po;
      e.busy = b;
      e.done = d;
      e.cnt  = CNT_W'(c);
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic clear_strobes();
      bus_if.start   = 1'b0;
      bus_if.stop    = 1'b0;
      bus_if.start_N = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      bit accepted, mode_n;
      int len, c;
      clear_strobes();
      bus_if.period       = CNT_W'(v.period);
      bus_if.width        = CNT_W'(v.width);
      bus_if.n_pulses     = CNT_W'(v.n);
      bus_if.pulse_invert = v.inv;
      tick(v.inv, 1'b0, 1'b0, cnt_model, {v.name, " setup"});

      mode_n = (v.kind == 1) || (v.kind == 2 && v.n != 0);
      case (v.kind)
         0, 2: accepted = (v.period != 0);
         1:    accepted = (v.period != 0) && (v.n != 0);
         default: accepted = 1'b0;
      endcase

      bus_if.start   = (v.kind == 0 || v.kind == 2);
      bus_if.start_N = (v.kind == 1 || v.kind == 2);
      bus_if.stop    = (v.kind == 3);

      if (!accepted) begin
         tick(v.inv, 1'b0, 1'b0, cnt_model, {v.name, " ignored"});
         clear_strobes();
         tick(v.inv, 1'b0, 1'b0, cnt_model, {v.name, " idle1"});
         tick(v.inv, 1'b0, 1'b0, cnt_model, {v.name, " idle2"});
         return;
      end

      if (mode_n) begin
         len = v.n * v.period;
         if (v.stop_after > 0 && v.stop_after < len) len = v.stop_after;
      end else begin
         len = v.stop_after;
      end

      for (int t = 0; t < len; t++) begin
         if (t > 0) begin
            // Config changes and new requests while busy must have no effect.
            bus_if.start   = (t % 2 == 1);
            bus_if.start_N = (t % 3 == 0);
            bus_if.stop    = 1'b0;
            bus_if.period  = CNT_W'(v.period + 1);
            bus_if.width   = CNT_W'(v.width ^ 1);
            bus_if.n_pulses = CNT_W'(v.n + 2);
         end
         c = t / v.period + 1;
         if (c > CNT_MAX) c = CNT_MAX;
         cnt_model = c;
         tick(((t % v.period) < v.width) ^ v.inv, 1'b1, 1'b0, c,
              $sformatf("%s busy t=%0d", v.name, t));
      end

      bus_if.stop = (v.stop_after > 0 && v.stop_after == len);
      tick(v.inv, 1'b0, 1'b1, cnt_model, {v.name, " done"});
      clear_strobes();
      tick(v.inv, 1'b0, 1'b0, cnt_model, {v.name, " after"});
   endtask

   initial begin
      //            kind P  W  N  inv stop name
      vecs[0] = '{1, 4, 1, 3, 1'b0, 0,  "burst_p4w1n3"};
      vecs[1] = '{0, 5, 2, 0, 1'b0, 12, "cont_p5w2_stop12"};
      vecs[2] = '{2, 2, 1, 2, 1'b0, 0,  "both_startN_wins"};
      vecs[3] = '{0, 0, 1, 0, 1'b0, 0,  "start_p0"};
      vecs[4] = '{1, 4, 1, 0, 1'b0, 0,  "startN_n0"};
      vecs[5] = '{3, 4, 1, 2, 1'b0, 0,  "stop_idle"};
      vecs[6] = '{0, 3, 3, 0, 1'b1, 7,  "inv_p3w3"};
      vecs[7] = '{1, 1, 0, 5, 1'b0, 0,  "burst_w0"};
      vecs[8] = '{1, 3, 5, 2, 1'b0, 0,  "burst_w_gt_p"};
      vecs[9] = '{0, 1, 1, 0, 1'b0, 20, "cont_saturate"};

      // Reset: outputs forced low even with invert set; start ignored.
      clear_strobes();
      bus_if.period       = CNT_W'(3);
      bus_if.width        = CNT_W'(1);
      bus_if.n_pulses     = CNT_W'(2);
      bus_if.pulse_invert = 1'b1;
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 0, "reset");
      bus_if.start = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 0, "reset_start_ignored");
      rst = 1'b1;
      bus_if.start = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 0, "reset_release_idle_inv");
      cnt_model = 0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Burst completion and stop in the same cycle: one done, count = n.
      begin
         vec_t v;
         v = '{1, 2, 1, 2, 1'b0, 4, "stop_at_completion"};
         run_vec(v);
      end

      // Reset mid-run: outputs drop to 0, no done, count cleared.
      clear_strobes();
      bus_if.period       = CNT_W'(3);
      bus_if.width        = CNT_W'(3);
      bus_if.pulse_invert = 1'b1;
      tick(1'b1, 1'b0, 1'b0, cnt_model, "rstmid setup");
      bus_if.start = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1, "rstmid t=0");
      bus_if.start = 1'b0;
      tick(1'b0, 1'b1, 1'b0, 1, "rstmid t=1");
      tick(1'b0, 1'b1, 1'b0, 1, "rstmid t=2");
      tick(1'b0, 1'b1, 1'b0, 2, "rstmid t=3");
      rst = 1'b0;
      bus_if.stop = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 0, "rstmid in_reset");
      rst = 1'b1;
      bus_if.stop = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 0, "rstmid released");
      tick(1'b1, 1'b0, 1'b0, 0, "rstmid no_done");

      // Invert is live in IDLE: follows one cycle after it changes.
      bus_if.pulse_invert = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 0, "invert_live");

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
